tabuleiro_armazena: RTL and testbench

- Board-side responder for the piece-placement FSM (PosicionandoPecas).
- Accepts a placement descriptor (tipo, jogador, X1, Y1, direcao, orientacao) qualified by valida.
- Checks every cell of the piece against the 8x8 board bounds and the player's existing pieces, then returns conflito together with a one-cycle concluido strobe.
- On a clean placement it writes the piece into that player's occupancy map; a registered query port serves the later attack phase.

---
 rtl/batalha_pkg.sv | 35 +++
 rtl/tabuleiro_armazena_if.sv | 25 ++
 rtl/tabuleiro_armazena_calc_celula.sv | 27 ++
 rtl/tabuleiro_armazena.sv | 131 +++++++++++++
 tb/tb_tabuleiro_armazena.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/batalha_pkg.sv
// Shared definitions for the battleship board: piece types, lengths, board size
// and the placement FSM state encoding.
package batalha_pkg;

   localparam int unsigned BOARD_DIM = 8;
   localparam int unsigned CELULAS   = BOARD_DIM * BOARD_DIM;

   typedef enum logic [2:0] {
      PORTA_AVIOES = 3'd0,
      ENCOURACADO  = 3'd1,
      HIDROAVIAO   = 3'd2,
      CRUZADOR     = 3'd3,
      SUBMARINO    = 3'd4
   } tipo_e;

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      WRITE,
      RESULT
   } estado_e;

   // Zero length marks an unknown piece type.
   function automatic logic [2:0] comprimento(input logic [2:0] tipo);
      case (tipo)
         PORTA_AVIOES: return 3'd5;
         ENCOURACADO:  return 3'd4;
         HIDROAVIAO:   return 3'd3;
         CRUZADOR:     return 3'd2;
         SUBMARINO:    return 3'd1;
         default:      return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/tabuleiro_armazena_if.sv
// Placement handshake between the piece-placement FSM and the board store.
interface tabuleiro_armazena_if;

   logic       valida;
   logic [2:0] tipo;
   logic       jogador;
   logic [2:0] X1;
   logic [2:0] Y1;
   logic       direcao;
   logic       orientacao;
   logic       conflito;
   logic       concluido;
   logic       ocupado_fsm;

   modport master (
      output valida, tipo, jogador, X1, Y1, direcao, orientacao,
      input  conflito, concluido, ocupado_fsm
   );

   modport slave (
      input  valida, tipo, jogador, X1, Y1, direcao, orientacao,
      output conflito, concluido, ocupado_fsm
   );

endinterface

// File: rtl/tabuleiro_armazena_calc_celula.sv
// Coordinates of cell k of a piece; any result outside 0..7 sets fora_limite.
module calc_celula (
   input  logic [2:0] x1,
   input  logic [2:0] y1,
   input  logic [2:0] k,
   input  logic       direcao,
   input  logic       orientacao,
   output logic [2:0] x,
   output logic [2:0] y,
   output logic       fora_limite
);

   logic [3:0] eixo;
   logic [3:0] passo;
   logic [3:0] soma;

   // 4-bit signed: both underflow (-1..-4) and overflow (8..11) land with bit 3 set.
   always_comb begin
      eixo        = direcao ? {1'b0, y1} : {1'b0, x1};
      passo       = {1'b0, k};
      soma        = orientacao ? (eixo - passo) : (eixo + passo);
      fora_limite = soma[3];
      x           = direcao ? x1 : soma[2:0];
      y           = direcao ? soma[2:0] : y1;
   end

endmodule

// File: rtl/tabuleiro_armazena.sv
// Board store: validates a piece placement cell by cell, writes it on success
// and serves registered occupancy queries for the attack phase.
module tabuleiro_armazena
   import batalha_pkg::*;
#(
   parameter int unsigned NUM_TIPOS = 5
) (
   input  logic                       clk,
   input  logic                       reset,
   tabuleiro_armazena_if.slave        pos,
   input  logic                       cons_jogador,
   input  logic [2:0]                 cons_x,
   input  logic [2:0]                 cons_y,
   output logic                       cons_ocupado,
   output logic [3:0]                 pecas_j0,
   output logic [3:0]                 pecas_j1
);

   estado_e                   estado;
   logic [1:0][CELULAS-1:0]   tabuleiro;
   logic [1:0][3:0]           pecas;
   logic [2:0]                k;

   logic                      r_invalido;
   logic [2:0]                r_len;
   logic                      r_jogador;
   logic [2:0]                r_x1;
   logic [2:0]                r_y1;
   logic                      r_direcao;
   logic                      r_orientacao;

   logic [2:0]                cel_x;
   logic [2:0]                cel_y;
   logic                      cel_fora;
   logic [5:0]                cel_idx;
   logic                      ultima;

   calc_celula u_calc (
      .x1          (r_x1),
      .y1          (r_y1),
      .k           (k),
      .direcao     (r_direcao),
      .orientacao  (r_orientacao),
      .x           (cel_x),
      .y           (cel_y),
      .fora_limite (cel_fora)
   );

   assign cel_idx  = {cel_y, cel_x};
   assign ultima   = (k == r_len - 3'd1);
   assign pecas_j0 = pecas[0];
   assign pecas_j1 = pecas[1];

   // An invalid type passes through one CHECK cycle so it reports after one edge,
   // like a conflict on the first cell.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado          <= IDLE;
         tabuleiro       <= '0;
         pecas           <= '0;
         k               <= '0;
         r_invalido      <= 1'b0;
         r_len           <= '0;
         r_jogador       <= 1'b0;
         r_x1            <= '0;
         r_y1            <= '0;
         r_direcao       <= 1'b0;
         r_orientacao    <= 1'b0;
         pos.conflito    <= 1'b0;
         pos.concluido   <= 1'b0;
         pos.ocupado_fsm <= 1'b0;
      end else begin
         pos.concluido <= 1'b0;
         unique case (estado)
            IDLE: begin
               if (pos.valida) begin
                  r_invalido      <= (32'(pos.tipo) >= NUM_TIPOS) ||
                                     (comprimento(pos.tipo) == 3'd0);
                  r_len           <= comprimento(pos.tipo);
                  r_jogador       <= pos.jogador;
                  r_x1            <= pos.X1;
                  r_y1            <= pos.Y1;
                  r_direcao       <= pos.direcao;
                  r_orientacao    <= pos.orientacao;
                  k               <= '0;
                  pos.conflito    <= 1'b0;
                  pos.ocupado_fsm <= 1'b1;
                  estado          <= CHECK;
               end
            end
            CHECK: begin
               if (r_invalido || cel_fora || tabuleiro[r_jogador][cel_idx]) begin
                  pos.conflito  <= 1'b1;
                  pos.concluido <= 1'b1;
                  estado        <= RESULT;
               end else if (ultima) begin
                  k      <= '0;
                  estado <= WRITE;
               end else begin
                  k <= k + 3'd1;
               end
            end
            WRITE: begin
               tabuleiro[r_jogador][cel_idx] <= 1'b1;
               if (ultima) begin
                  if (pecas[r_jogador] != 4'hF)
                     pecas[r_jogador] <= pecas[r_jogador] + 4'd1;
                  pos.conflito  <= 1'b0;
                  pos.concluido <= 1'b1;
                  estado        <= RESULT;
               end else begin
                  k <= k + 3'd1;
               end
            end
            RESULT: begin
               pos.ocupado_fsm <= 1'b0;
               estado          <= IDLE;
            end
            default: estado <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cons_ocupado <= 1'b0;
      else
         cons_ocupado <= tabuleiro[cons_jogador][{cons_y, cons_x}];
   end

endmodule

// File: tb/tb_tabuleiro_armazena.sv
// Directed bench for tabuleiro_armazena: placement latency, conflicts, bounds,
// per-player boards, busy handling and mid-operation reset.
module tb_tabuleiro_armazena;

   logic       clk = 1'b0;
   logic       reset;
   logic       cons_jogador;
   logic [2:0] cons_x;
   logic [2:0] cons_y;
   logic       cons_ocupado;
   logic [3:0] pecas_j0;
   logic [3:0] pecas_j1;

   int checks = 0;
   int errors = 0;

   tabuleiro_armazena_if pos ();

   tabuleiro_armazena #(.NUM_TIPOS(5)) dut (
      .clk          (clk),
      .reset        (reset),
      .pos          (pos),
      .cons_jogador (cons_jogador),
      .cons_x       (cons_x),
      .cons_y       (cons_y),
      .cons_ocupado (cons_ocupado),
      .pecas_j0     (pecas_j0),
      .pecas_j1     (pecas_j1)
   );

   always #5 clk = ~clk;

   task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      checks++;
      if (obs !== esp) begin
         errors++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, esp);
      end
   endtask

   // Drives one descriptor through its accepting edge, then scrambles the inputs.
   task automatic aceita(input logic [2:0] t, input logic j, input logic [2:0] x, input logic [2:0] y,
                         input logic d, input logic o);
      pos.valida     = 1'b1;
      pos.tipo       = t;
      pos.jogador    = j;
      pos.X1         = x;
      pos.Y1         = y;
      pos.direcao    = d;
      pos.orientacao = o;
      @(posedge clk); #1;
      pos.valida     = 1'b0;
      pos.tipo       = ~t;
      pos.jogador    = ~j;
      pos.X1         = ~x;
      pos.Y1         = ~y;
      pos.direcao    = ~d;
      pos.orientacao = ~o;
   endtask

   task automatic coloca(input logic [2:0] t, input logic j, input logic [2:0] x, input logic [2:0] y,
                         input logic d, input logic o, output int lat, output logic conf);
      aceita(t, j, x, y, d, o);
      lat  = -1;
      conf = 1'bx;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk); #1;
         if (pos.concluido) begin
            lat  = i;
            conf = pos.conflito;
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic consulta(input logic j, input logic [2:0] x, input logic [2:0] y, output logic v);
      cons_jogador = j;
      cons_x       = x;
      cons_y       = y;
      @(posedge clk); #1;
      v = cons_ocupado;
   endtask

   initial begin
      int   lat;
      logic conf;
      logic v;
      int   pulsos;
      int   borda;

      reset          = 1'b0;
      pos.valida     = 1'b0;
      pos.tipo       = '0;
      pos.jogador    = 1'b0;
      pos.X1         = '0;
      pos.Y1         = '0;
      pos.direcao    = 1'b0;
      pos.orientacao = 1'b0;
      cons_jogador   = 1'b0;
      cons_x         = '0;
      cons_y         = '0;

      repeat (3) @(posedge clk);
      #1;
      verifica("rst_concluido", pos.concluido, 0);
      verifica("rst_conflito", pos.conflito, 0);
      verifica("rst_ocupado", pos.ocupado_fsm, 0);
      verifica("rst_cons", cons_ocupado, 0);
      verifica("rst_pecas_j0", pecas_j0, 0);
      verifica("rst_pecas_j1", pecas_j1, 0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Carrier horizontal at (2,2) on board 0: cells x=2..6.
      coloca(3'd0, 1'b0, 3'd2, 3'd2, 1'b0, 1'b0, lat, conf);
      verifica("t1_lat", lat, 10);
      verifica("t1_conf", conf, 0);
      verifica("t1_ocupado_idle", pos.ocupado_fsm, 0);
      for (int x = 2; x <= 6; x++) begin
         consulta(1'b0, 3'(x), 3'd2, v);
         verifica($sformatf("t1_cel_%0d_2", x), v, 1);
      end
      consulta(1'b0, 3'd7, 3'd2, v);
      verifica("t1_cel_7_2", v, 0);
      consulta(1'b0, 3'd1, 3'd2, v);
      verifica("t1_cel_1_2", v, 0);
      verifica("t1_pecas_j0", pecas_j0, 1);

      // Vertical battleship from (4,0) hits (4,2) at k=2.
      coloca(3'd1, 1'b0, 3'd4, 3'd0, 1'b1, 1'b0, lat, conf);
      verifica("t2_lat", lat, 3);
      verifica("t2_conf", conf, 1);
      consulta(1'b0, 3'd4, 3'd0, v);
      verifica("t2_cel_4_0", v, 0);
      consulta(1'b0, 3'd4, 3'd1, v);
      verifica("t2_cel_4_1", v, 0);
      verifica("t2_pecas_j0", pecas_j0, 1);

      // Carrier at (6,5) running +x leaves the board at x=8.
      coloca(3'd0, 1'b0, 3'd6, 3'd5, 1'b0, 1'b0, lat, conf);
      verifica("t3_lat", lat, 3);
      verifica("t3_conf", conf, 1);
      consulta(1'b0, 3'd6, 3'd5, v);
      verifica("t3_cel_6_5_vazia", v, 0);
      // Same piece running -x: cells 6..2.
      coloca(3'd0, 1'b0, 3'd6, 3'd5, 1'b0, 1'b1, lat, conf);
      verifica("t3b_lat", lat, 10);
      verifica("t3b_conf", conf, 0);
      consulta(1'b0, 3'd2, 3'd5, v);
      verifica("t3b_cel_2_5", v, 1);
      consulta(1'b0, 3'd6, 3'd5, v);
      verifica("t3b_cel_6_5", v, 1);
      consulta(1'b0, 3'd7, 3'd5, v);
      verifica("t3b_cel_7_5", v, 0);
      consulta(1'b0, 3'd1, 3'd5, v);
      verifica("t3b_cel_1_5", v, 0);
      verifica("t3b_pecas_j0", pecas_j0, 2);

      // Same cells as the first piece, but on board 1.
      coloca(3'd0, 1'b1, 3'd2, 3'd2, 1'b0, 1'b0, lat, conf);
      verifica("t4_lat", lat, 10);
      verifica("t4_conf", conf, 0);
      verifica("t4_pecas_j1", pecas_j1, 1);
      verifica("t4_pecas_j0", pecas_j0, 2);
      consulta(1'b1, 3'd6, 3'd2, v);
      verifica("t4_j1_cel_6_2", v, 1);
      consulta(1'b1, 3'd6, 3'd5, v);
      verifica("t4_j1_cel_6_5", v, 0);
      consulta(1'b0, 3'd7, 3'd2, v);
      verifica("t4_j0_cel_7_2", v, 0);

      // Invalid type.
      coloca(3'd5, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, lat, conf);
      verifica("t5_lat", lat, 1);
      verifica("t5_conf", conf, 1);
      verifica("t5_pecas_j0", pecas_j0, 2);

      // Cruiser at (0,7) on board 1; valida held with another descriptor through RESULT.
      aceita(3'd3, 1'b1, 3'd0, 3'd7, 1'b0, 1'b0);
      pos.valida     = 1'b1;
      pos.tipo       = 3'd4;
      pos.jogador    = 1'b1;
      pos.X1         = 3'd5;
      pos.Y1         = 3'd5;
      pos.direcao    = 1'b0;
      pos.orientacao = 1'b0;
      pulsos = 0;
      borda  = -1;
      for (int i = 1; i <= 15; i++) begin
         @(posedge clk); #1;
         if (i == 5) pos.valida = 1'b0;
         if (pos.concluido) begin
            pulsos++;
            if (borda < 0) begin
               borda = i;
               verifica("t6_conf", pos.conflito, 0);
            end
         end
      end
      verifica("t6_pulsos", pulsos, 1);
      verifica("t6_lat", borda, 4);
      verifica("t6_ocupado", pos.ocupado_fsm, 0);
      consulta(1'b1, 3'd1, 3'd7, v);
      verifica("t6_cel_1_7", v, 1);
      consulta(1'b1, 3'd5, 3'd5, v);
      verifica("t6_ignorada_5_5", v, 0);
      verifica("t6_pecas_j1", pecas_j1, 2);

      // Reset during WRITE: two cells of (0,0)..(4,0) already written.
      aceita(3'd0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
      repeat (7) @(posedge clk);
      #1;
      verifica("t7_ocupado_antes", pos.ocupado_fsm, 1);
      reset = 1'b0;
      #1;
      verifica("t7_ocupado_rst", pos.ocupado_fsm, 0);
      verifica("t7_pecas_j1_rst", pecas_j1, 0);
      repeat (2) @(posedge clk);
      #1;
      reset  = 1'b1;
      pulsos = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (pos.concluido) pulsos++;
      end
      verifica("t7_sem_concluido", pulsos, 0);
      consulta(1'b0, 3'd0, 3'd0, v);
      verifica("t7_cel_0_0", v, 0);
      consulta(1'b0, 3'd1, 3'd0, v);
      verifica("t7_cel_1_0", v, 0);
      consulta(1'b0, 3'd2, 3'd2, v);
      verifica("t7_j0_cel_2_2", v, 0);
      consulta(1'b1, 3'd2, 3'd2, v);
      verifica("t7_j1_cel_2_2", v, 0);
      verifica("t7_pecas_j0", pecas_j0, 0);

      coloca(3'd4, 1'b0, 3'd3, 3'd3, 1'b1, 1'b1, lat, conf);
      verifica("t8_lat", lat, 2);
      verifica("t8_conf", conf, 0);
      consulta(1'b0, 3'd3, 3'd3, v);
      verifica("t8_cel_3_3", v, 1);
      verifica("t8_pecas_j0", pecas_j0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
